// File: rtl/bit_population_emitter_if.sv
// rtl/bit_population_emitter_if.sv - word-in / index-out handshake bundle for the set-bit emitter.
interface bit_population_emitter_if #(
  parameter int WIDTH = 128
);
  localparam int IW = $clog2(WIDTH);
  localparam int CW = IW + 1;

  logic [WIDTH-1:0] data_i;
  logic             data_val_i;
  logic             data_ready_o;
  logic [IW-1:0]    idx_o;
  logic             idx_val_o;
  logic             idx_ready_i;
  logic             idx_last_o;
  logic             empty_o;
  logic [CW-1:0]    total_o;

  modport slave (
    input  data_i, data_val_i, idx_ready_i,
    output data_ready_o, idx_o, idx_val_o, idx_last_o, empty_o, total_o
  );

  modport master (
    output data_i, data_val_i, idx_ready_i,
    input  data_ready_o, idx_o, idx_val_o, idx_last_o, empty_o, total_o
  );
endinterface

// File: rtl/bit_population_emitter.sv
// rtl/bit_population_emitter.sv - expands an accepted word into a stream of its set-bit indices, LSB first.
module bit_population_emitter #(
  parameter int WIDTH = 128
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  bit_population_emitter_if.slave  bus
);
  localparam int IW = $clog2(WIDTH);
  localparam int CW = IW + 1;

  typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] w_mask_nxt;
  logic [IW-1:0]    r_idx;
  logic             r_last;
  logic             r_empty;
  logic [CW-1:0]    r_total;
  logic             w_ready;
  logic             w_val;
  logic             w_in_acc;
  logic             w_out_acc;

  function automatic logic [IW-1:0] f_lowbit(input logic [WIDTH-1:0] m);
    logic [IW-1:0] v;
    v = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (m[i]) v = IW'(i);
    end
    return v;
  endfunction

  function automatic logic [CW-1:0] f_popcnt(input logic [WIDTH-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + CW'(m[i]);
    end
    return c;
  endfunction

  function automatic logic f_single(input logic [WIDTH-1:0] m);
    return (m != '0) && ((m & (m - WIDTH'(1))) == '0);
  endfunction

  // State register
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next state and residual mask
  always_comb begin
    w_in_acc    = bus.data_val_i && w_ready;
    w_out_acc   = w_val && bus.idx_ready_i;
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    if (w_in_acc) begin
      w_state_nxt = S_EMIT;
      w_mask_nxt  = bus.data_i;
    end else if (w_out_acc) begin
      if (r_last) begin
        w_state_nxt = S_IDLE;
        w_mask_nxt  = '0;
      end else begin
        w_mask_nxt  = r_mask & (r_mask - WIDTH'(1));
      end
    end
  end

  // Outputs; ready on the last-beat handoff lets the next word load without a bubble
  always_comb begin
    w_val   = (r_state == S_EMIT);
    w_ready = (r_state == S_IDLE) || (w_val && r_last && bus.idx_ready_i);
  end

  // Beat registers are computed from the next mask so every idx-side output is a flop
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_mask  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_empty <= 1'b0;
      r_total <= '0;
    end else begin
      r_mask <= w_mask_nxt;
      if (w_state_nxt == S_EMIT) begin
        r_idx  <= f_lowbit(w_mask_nxt);
        r_last <= (w_mask_nxt == '0) || f_single(w_mask_nxt);
      end else begin
        r_idx  <= '0;
        r_last <= 1'b0;
      end
      if (w_in_acc) begin
        r_empty <= (bus.data_i == '0);
        r_total <= f_popcnt(bus.data_i);
      end else if (w_state_nxt == S_IDLE) begin
        r_empty <= 1'b0;
        r_total <= '0;
      end
    end
  end

  assign bus.data_ready_o = w_ready;
  assign bus.idx_val_o    = w_val;
  assign bus.idx_o        = r_idx;
  assign bus.idx_last_o   = r_last;
  assign bus.empty_o      = r_empty;
  assign bus.total_o      = r_total;

endmodule

// File: tb/tb_bit_population_emitter.sv
// tb/tb_bit_population_emitter.sv - scoreboard bench for bit_population_emitter at WIDTH=8.
module tb_bit_population_emitter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit_population_emitter_if #(.WIDTH(W)) bus ();

  bit_population_emitter #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .arst_n_i (rst_n),
    .bus      (bus)
  );

  typedef struct {
    int idx;
    int last;
    int empty;
    int total;
  } beat_t;

  beat_t exp_q[$];
  int    beat_ticks[$];
  int    tick = 0;
  int    t_acc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  bit    rand_ready = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: ascending set-bit positions, or one empty beat for a zero word
  task automatic push_word(input logic [W-1:0] w);
    int cnt;
    int n;
    cnt = 0;
    for (int i = 0; i < W; i++) if (w[i]) cnt++;
    n = 0;
    for (int i = 0; i < W; i++) begin
      if (w[i]) begin
        n++;
        exp_q.push_back('{i, (n == cnt) ? 1 : 0, 0, cnt});
      end
    end
    if (cnt == 0) exp_q.push_back('{0, 1, 1, 0});
  endtask

  always @(posedge clk) tick <= tick + 1;

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 bus.idx_ready_i = 1'($urandom_range(0, 1));
    end
  end

  int p_stall = 0;
  int p_idx, p_total, p_last, p_empty;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_stall = 0;
    end else begin
      if (p_stall != 0) begin
        chk("stall_val", int'(bus.idx_val_o), 1);
        chk("stall_idx", int'(bus.idx_o), p_idx);
        chk("stall_total", int'(bus.total_o), p_total);
        chk("stall_last", int'(bus.idx_last_o), p_last);
        chk("stall_empty", int'(bus.empty_o), p_empty);
      end
      if (bus.idx_val_o && bus.idx_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_idx", int'(bus.idx_o), -1);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_idx", int'(bus.idx_o), e.idx);
          chk("beat_last", int'(bus.idx_last_o), e.last);
          chk("beat_empty", int'(bus.empty_o), e.empty);
          chk("beat_total", int'(bus.total_o), e.total);
        end
        beat_ticks.push_back(tick);
      end
      p_stall = (bus.idx_val_o && !bus.idx_ready_i) ? 1 : 0;
      p_idx   = int'(bus.idx_o);
      p_total = int'(bus.total_o);
      p_last  = int'(bus.idx_last_o);
      p_empty = int'(bus.empty_o);
    end
  end

  // Presents a word and returns at the negedge just before the edge that accepts it
  task automatic drive_word(input logic [W-1:0] w);
    @(posedge clk);
    #1;
    bus.data_i     = w;
    bus.data_val_i = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.data_ready_o) begin
        push_word(w);
        t_acc = tick;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic idle_in();
    @(posedge clk);
    #1;
    bus.data_val_i = 1'b0;
    bus.data_i     = W'($urandom);
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.idx_val_o) break;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_val", int'(bus.idx_val_o), 0);
  endtask

  task automatic chk_ticks(input string name, input int base, input int n);
    chk({name, "_count"}, beat_ticks.size(), n);
    for (int k = 0; k < n && k < beat_ticks.size(); k++) chk({name, "_tick"}, beat_ticks[k], base + 1 + k);
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_val"}, int'(bus.idx_val_o), 0);
    chk({name, "_idx"}, int'(bus.idx_o), 0);
    chk({name, "_last"}, int'(bus.idx_last_o), 0);
    chk({name, "_empty"}, int'(bus.empty_o), 0);
    chk({name, "_total"}, int'(bus.total_o), 0);
    chk({name, "_ready"}, int'(bus.data_ready_o), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [W-1:0] w;
    bus.data_i      = '0;
    bus.data_val_i  = 1'b0;
    bus.idx_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_zero_outputs("reset");

    // 8'b1010_0101 with ready held high
    beat_ticks.delete();
    drive_word(8'hA5);
    t0 = t_acc;
    idle_in();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("a5_val", int'(bus.idx_val_o), 1);
      chk("a5_dready", int'(bus.data_ready_o), (k == 3) ? 1 : 0);
    end
    wait_drain(20);
    chk_ticks("a5", t0, 4);

    // zero word
    drive_word(8'h00);
    idle_in();
    @(negedge clk);
    chk("zero_empty", int'(bus.empty_o), 1);
    wait_drain(20);
    chk("zero_idle_ready", int'(bus.data_ready_o), 1);

    // 8'hFF then 8'h80 on the last-beat handoff edge
    beat_ticks.delete();
    drive_word(8'hFF);
    t0 = t_acc;
    drive_word(8'h80);
    chk("b2b_accept_tick", t_acc, t0 + 8);
    idle_in();
    wait_drain(30);
    chk_ticks("b2b", t0, 9);

    // backpressure with ignored data_val pulses
    bus.idx_ready_i = 1'b0;
    drive_word(8'b0001_0010);
    idle_in();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_val", int'(bus.idx_val_o), 1);
      chk("bp_idx", int'(bus.idx_o), 1);
      chk("bp_total", int'(bus.total_o), 2);
      chk("bp_dready", int'(bus.data_ready_o), 0);
      @(posedge clk);
      #1;
      bus.data_val_i = (k != 2);
      bus.data_i     = W'($urandom);
    end
    bus.data_val_i  = 1'b0;
    bus.idx_ready_i = 1'b1;
    wait_drain(20);

    // asynchronous reset during beat 2 of 8'hF0
    drive_word(8'hF0);
    idle_in();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_zero_outputs("post_reset");
    drive_word(8'h01);
    idle_in();
    @(negedge clk);
    chk("after_reset_last", int'(bus.idx_last_o), 1);
    wait_drain(20);

    // randomised regression
    rand_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) idle_in();
      case ($urandom_range(0, 4))
        0:       w = '0;
        1:       w = W'(1) << $urandom_range(0, W - 1);
        2:       w = '1;
        default: w = W'($urandom);
      endcase
      drive_word(w);
    end
    idle_in();
    rand_ready = 1'b0;
    @(posedge clk);
    #2 bus.idx_ready_i = 1'b1;
    wait_drain(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
